// File: rtl/jcsa_mpadd_ctrl.sv
// jcsa_mpadd_ctrl
//   Multi-precision add/subtract sequencer. One WORDS x 8-bit operand pair is
//   accepted on a valid/ready handshake. A single 8-bit carry-skip adder then
//   walks the operands one byte per cycle, least-significant byte first. The
//   carry is registered between bytes. The full result, carry-out and signed
//   overflow are presented on a valid/ready output handshake.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept a request (IDLE only)
//   a, b       N-bit operands, N = 8*WORDS
//   cin        carry-in for add; ignored for subtract
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        N-bit result, modulo 2^N
//   cout       final carry-out (for subtract, 1 = no borrow)
//   ovf        signed two's-complement overflow
//
// jcarryskipadder
//   8-bit adder made of two 4-bit ripple blocks with a skip mux per block.

module jcarryskipadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carryin,
  output logic [7:0] y,
  output logic       carryout
);

  // When every bit in a 4-bit block propagates, the block's carry-out equals
  // its carry-in. The skip mux forwards that carry directly, so the long
  // path avoids the ripple chain. The result is identical either way.
  always_comb begin : add
    logic [8:0] c;
    logic [7:0] p;
    p    = a ^ b;
    c    = '0;
    c[0] = carryin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    if (&p[3:0]) begin
      c[4] = c[0];
    end
    for (int i = 4; i < 8; i++) begin
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    if (&p[7:4]) begin
      c[8] = c[4];
    end
    y        = p ^ c[7:0];
    carryout = c[8];
  end

endmodule

module jcsa_mpadd_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int N  = 8 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  areg;
  logic [N-1:0]  breg;
  logic          carry;
  logic [IW-1:0] idx;
  logic [7:0]    abyte;
  logic [7:0]    bbyte;
  logic [7:0]    addy;
  logic          addco;

  // Current byte of the latched operands feeds the shared adder.
  always_comb begin
    abyte = areg[8*idx +: 8];
    bbyte = breg[8*idx +: 8];
  end

  jcarryskipadder u_adder (
    .a        (abyte),
    .b        (bbyte),
    .carryin  (carry),
    .y        (addy),
    .carryout (addco)
  );

  // Sequencer. breg holds the effective B (~b for subtract). carry starts at
  // 1 for subtract, which completes the two's complement. Because both
  // choices are baked in at acceptance, sub needs no storage of its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      areg      <= '0;
      breg      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            areg     <= a;
            breg     <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[8*idx +: 8] <= addy;
          carry           <= addco;
          if (idx == LAST) begin
            cout      <= addco;
            // Overflow when both operands share a sign that the result lacks.
            ovf       <= (areg[N-1] == breg[N-1]) && (addy[7] != areg[N-1]);
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
